instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/ifu_pkg.sv | 15 +
 rtl/instruction_fetch_unit_if.sv | 10 +
 rtl/ifu_prefetch_buf.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int          INSTR_W    = 32;
  localparam int          OPCODE_W   = 10;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR    = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: one request, one ack per word.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifu_prefetch_buf.sv
// One-entry prefetch register; flush has priority over load.
module ifu_prefetch_buf
  import ifu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_data,
  output logic               valid,
  output logic [INSTR_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer with a single outstanding memory read.
// Define IFU_PREFETCH_EN to add a one-entry pc+4 prefetch buffer.
//
// state | meaning
// FETCH | request pc_next, wait for ack
// HOLD  | instruction presented, wait for acceptance
// HALT  | all-zero instruction accepted, idle until reset
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BR_OFF_W = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master imem,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instruction,
  output logic [OPCODE_W-1:0]      opcode,
  output logic [31:0]              pc,
  input  logic                     branch,
  input  logic [BR_OFF_W-1:0]      branch_offset,
  output logic                     halted
);

  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] HOLD  = ST_HOLD;
  localparam logic [1:0] HALT  = ST_HALT;

  logic [1:0]         state;
  logic [31:0]        pc_next;
  logic [31:0]        pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               accept;
  logic               is_halt;
  logic [31:0]        off_ext;
  logic [31:0]        seq_pc;
  logic [31:0]        br_target;

  assign accept    = (state == HOLD) && instr_ready;
  assign is_halt   = (instr_q == HALT_INSTR);
  assign off_ext   = {{(32-BR_OFF_W){branch_offset[BR_OFF_W-1]}}, branch_offset};
  assign seq_pc    = pc_q + PC_INCR;
  assign br_target = pc_q + (off_ext << 2);

`ifdef IFU_PREFETCH_EN
  logic               buf_valid;
  logic [INSTR_W-1:0] buf_data;
  logic               pf_req;
  logic               pf_ack;
  logic               pf_stale;

  assign pf_req = (state == HOLD) && !buf_valid;
  assign pf_ack = pf_req && imem.imem_ack;

  // Any acceptance empties the buffer: consumed on sequential flow, discarded on branch/halt.
  ifu_prefetch_buf u_prefetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (accept),
    .load      (pf_ack && !accept),
    .load_data (imem.imem_rdata),
    .valid     (buf_valid),
    .data      (buf_data)
  );

  // A prefetch cut off by a branch keeps its address until its ack is drained.
  assign imem.imem_req  = rst_n && ((state == FETCH) || pf_req);
  assign imem.imem_addr = ((state == FETCH) && !pf_stale) ? pc_next : seq_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc_next  <= RESET_PC;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pf_stale <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem.imem_ack) begin
          if (pf_stale) begin
            pf_stale <= 1'b0;
          end else begin
            instr_q <= imem.imem_rdata;
            pc_q    <= pc_next;
            state   <= HOLD;
          end
        end
        HOLD: if (accept) begin
          if (is_halt) begin
            state <= HALT;
          end else if (branch) begin
            pc_next  <= br_target;
            pf_stale <= pf_req && !imem.imem_ack;
            state    <= FETCH;
          end else if (buf_valid) begin
            instr_q <= buf_data;
            pc_q    <= seq_pc;
          end else if (pf_ack) begin
            instr_q <= imem.imem_rdata;
            pc_q    <= seq_pc;
          end else begin
            pc_next <= seq_pc;
            state   <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign imem.imem_req  = rst_n && (state == FETCH);
  assign imem.imem_addr = pc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc_next <= RESET_PC;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      case (state)
        FETCH: if (imem.imem_ack) begin
          instr_q <= imem.imem_rdata;
          pc_q    <= pc_next;
          state   <= HOLD;
        end
        HOLD: if (accept) begin
          if (is_halt) begin
            state <= HALT;
          end else begin
            pc_next <= branch ? br_target : seq_pc;
            state   <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  assign instr_valid = (state == HOLD);
  assign halted      = (state == HALT);
  assign instruction = instr_q;
  assign opcode      = instr_q[INSTR_W-1 -: OPCODE_W];
  assign pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (table vectors, random flow, corner sequences).
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [9:0]  opcode;
  logic [31:0] pc;
  logic        branch = 1'b0;
  logic [25:0] branch_offset = '0;
  logic        halted;

  always #5 clk = ~clk;

  instruction_fetch_unit_if imem_bus ();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .BR_OFF_W(26)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .opcode        (opcode),
    .pc            (pc),
    .branch        (branch),
    .branch_offset (branch_offset),
    .halted        (halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h1;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge while the DUT should be fetching `addr`.
  task automatic fetch_and_check(input logic [31:0] addr, input int lat);
    logic [31:0] w;
    int n;
    w = mem_word(addr);
    n = 0;
    while (!imem_bus.imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_bus.imem_req) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: got no imem_req, expected request for %h", addr);
      return;
    end
    chk32("req_addr", imem_bus.imem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      imem_bus.imem_ack = 1'b0;
      instr_ready = 1'($urandom);
      branch      = 1'($urandom);
      @(negedge clk);
      chk1("req_held", imem_bus.imem_req, 1'b1);
      chk32("addr_stable", imem_bus.imem_addr, addr);
      chk1("valid_early", instr_valid, 1'b0);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = w;
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom;
    instr_ready = 1'b0;
    branch      = 1'b0;
    chk1("valid_after_ack", instr_valid, 1'b1);
    chk32("pc", pc, addr);
    chk32("instruction", instruction, w);
    chk32("opcode", 32'(opcode), 32'(w[31:22]));
    chk1("no_req_in_hold", imem_bus.imem_req, 1'b0);
  endtask

  // Holds ready low `delay` cycles, then accepts with the given branch decision.
  task automatic accept(input logic [31:0] exp_pc, input logic br, input int off, input int delay);
    logic [31:0] w;
    w = mem_word(exp_pc);
    for (int i = 0; i < delay; i++) begin
      instr_ready   = 1'b0;
      branch        = 1'($urandom);
      branch_offset = 26'($urandom);
      @(negedge clk);
      chk1("hold_valid", instr_valid, 1'b1);
      chk32("hold_pc", pc, exp_pc);
      chk32("hold_instr", instruction, w);
      chk1("hold_no_req", imem_bus.imem_req, 1'b0);
    end
    instr_ready   = 1'b1;
    branch        = br;
    branch_offset = 26'(off);
    @(negedge clk);
    instr_ready = 1'b0;
    branch      = 1'b0;
  endtask

  typedef struct {
    logic [31:0] exp_pc;
    logic        br;
    int          off;
    int          lat;
    int          delay;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] cur;
    logic [31:0] nxt;
    logic        br;
    int          off;

    vecs[0]  = '{32'h0000_0000, 1'b0,  0,         1, 5, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0004, 1'b0,  0,         0, 0, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0008, 1'b1, -2,         2, 1, 32'h0000_0000};
    vecs[3]  = '{32'h0000_0000, 1'b0,  0,         0, 0, 32'h0000_0004};
    vecs[4]  = '{32'h0000_0004, 1'b0,  0,         1, 2, 32'h0000_0008};
    vecs[5]  = '{32'h0000_0008, 1'b1,  3,         0, 0, 32'h0000_0014};
    vecs[6]  = '{32'h0000_0014, 1'b1, -5,         3, 1, 32'h0000_0000};
    vecs[7]  = '{32'h0000_0000, 1'b1, -1,         0, 0, 32'hFFFF_FFFC};
    vecs[8]  = '{32'hFFFF_FFFC, 1'b0,  0,         1, 0, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0000, 1'b1,  33554431,  0, 1, 32'h07FF_FFFC};
    vecs[10] = '{32'h07FF_FFFC, 1'b1, -33554432,  2, 0, 32'hFFFF_FFFC};
    vecs[11] = '{32'hFFFF_FFFC, 1'b1,  2,         0, 0, 32'h0000_0004};

    mem_ovr[32'h0] = 32'h8B00_0001;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;

    repeat (2) @(negedge clk);
    chk1("rst_req", imem_bus.imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk32("rst_pc", pc, RESET_PC);
    chk32("rst_instr", instruction, 32'h0);
    rst_n = 1'b1;
    #1;
    chk1("first_req", imem_bus.imem_req, 1'b1);
    chk32("first_addr", imem_bus.imem_addr, RESET_PC);

`ifdef IFU_PREFETCH_EN
    begin
      logic [31:0] exp;
      int seen, gap, cycles;
      logic after_br, tgt_checked;
      exp = RESET_PC; seen = 0; gap = 0; cycles = 0;
      after_br = 1'b0; tgt_checked = 1'b0;
      while (seen < 16 && cycles < 200) begin
        imem_bus.imem_ack   = imem_bus.imem_req;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        if (instr_valid) begin
          chk32("pf_pc", pc, exp);
          chk32("pf_instr", instruction, mem_word(exp));
          if (seen > 0 && !after_br) chk32("pf_back_to_back_gap", 32'(gap), 32'd0);
          br = (seen == 8);
          instr_ready   = 1'b1;
          branch        = br;
          branch_offset = br ? 26'(-16) : 26'd0;
          exp = br ? exp + 32'(-64) : exp + 32'd4;
          seen++;
          gap = 0;
          after_br = br;
        end else begin
          instr_ready = 1'b0;
          branch      = 1'b0;
          gap++;
          if (after_br && !tgt_checked && imem_bus.imem_req) begin
            chk32("pf_branch_target", imem_bus.imem_addr, exp);
            tgt_checked = 1'b1;
          end
        end
        @(negedge clk);
        cycles++;
      end
      imem_bus.imem_ack = 1'b0;
      instr_ready = 1'b0;
      chk32("pf_instr_count", 32'(seen), 32'd16);
      chk1("pf_target_seen", tgt_checked, 1'b1);
    end
`else
    for (int i = 0; i < 12; i++) begin
      fetch_and_check(vecs[i].exp_pc, vecs[i].lat);
      if (i == 0) chk32("first_opcode", 32'(opcode), 32'h22C);
      accept(vecs[i].exp_pc, vecs[i].br, vecs[i].off, vecs[i].delay);
      chk1("bubble", instr_valid, 1'b0);
      chk32("next_addr", imem_bus.imem_addr, vecs[i].exp_next);
    end

    cur = 32'h0000_0004;
    for (int k = 0; k < 40; k++) begin
      fetch_and_check(cur, int'($urandom_range(0, 3)));
      br  = ($urandom_range(0, 2) == 0);
      off = int'($urandom_range(0, 127)) - 64;
      accept(cur, br, off, int'($urandom_range(0, 2)));
      nxt = br ? cur + 32'(off * 4) : cur + 32'd4;
      chk32("rand_next_addr", imem_bus.imem_addr, nxt);
      cur = nxt;
    end

    // Halt on an all-zero word; the branch flag on that acceptance must be ignored.
    mem_ovr[cur] = 32'h0;
    fetch_and_check(cur, 1);
    accept(cur, 1'b1, 7, 2);
    chk1("halted", halted, 1'b1);
    chk1("halt_valid", instr_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      instr_ready = 1'($urandom);
      @(negedge clk);
      chk1("halt_no_req", imem_bus.imem_req, 1'b0);
      chk1("halt_stays", halted, 1'b1);
    end
    instr_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("halt_rst_halted", halted, 1'b0);
    chk1("halt_rst_valid", instr_valid, 1'b0);
    chk32("halt_rst_pc", pc, RESET_PC);
    chk1("halt_rst_req", imem_bus.imem_req, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("restart_req", imem_bus.imem_req, 1'b1);
    chk32("restart_addr", imem_bus.imem_addr, RESET_PC);
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h8B00_0001;
    fetch_and_check(RESET_PC, 0);
    accept(RESET_PC, 1'b1, 64, 0);
    chk32("jump_addr", imem_bus.imem_addr, 32'h0000_0100);

    // Reset coincident with an ack: the word must be dropped.
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    chk1("rst_ack_valid", instr_valid, 1'b0);
    chk32("rst_ack_instr", instruction, 32'h0);
    chk32("rst_ack_pc", pc, RESET_PC);
    rst_n = 1'b1;
    #1;
    chk32("rst_ack_addr", imem_bus.imem_addr, RESET_PC);
    fetch_and_check(RESET_PC, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
